multi_scoreboard: RTL and testbench
===================================

# multi_scoreboard

Parametrised match scoreboard for the tug-of-war game family: N players, configurable score width, target points and win-by margin. Counts one point per completed round from a one-hot `winner` code qualified by `done`, declares a match winner, and freezes until cleared. It sits between the round engine (tugowar / CyberPlayer) and the HEX display drivers.

## Interface
- NUM_PLAYERS, 2, number of players, 2..8; player 0 is cyber/left, player 1 is human/right
- SCORE_W, 3, bits per player score, 2..6
- MATCH_POINTS, 7, points needed to win, 1..2^SCORE_W-1
- WIN_BY, 1, required lead over the best other player, 1..3
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- clear_match  in  1  synchronous soft clear of the match; level, sampled each edge
- done  in  1  round complete; level-high after a win
- winner  in  NUM_PLAYERS  one-hot round winner; all-zero means draw
- scores  out  NUM_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W]
- match_over  out  1  match decided; further rounds ignored
- match_winner  out  NUM_PLAYERS  one-hot match winner; zero while undecided
- rounds  out  8  rounds committed, including draws; saturates at 255
- score_evt  out  1  one-cycle pulse on each committed round
- bad_winner  out  1  sticky flag: commit saw a multi-hot winner

## Operation
- Rise detect: done_rise = done & ~done_q. done_q resets to 1, so a done held high through reset release is not counted; done must go low, then high.
- Arm: on done_rise with !match_over, set pending.
- Commit, on the edge after arming, always clearing pending:
  - If done is still high: winner one-hot -> that player's score +1; winner zero -> draw, no score change; winner multi-hot -> no score change and bad_winner sets.
  - rounds increments and score_evt pulses in all three cases.
  - If done dropped before the commit edge: discard, with no rounds increment and no pulse.
- Saturation: a score never exceeds 2^SCORE_W-1.
- Match decision: player p wins when score_p >= MATCH_POINTS and score_p − max(other scores) >= WIN_BY. A player that scores while already at 2^SCORE_W-1, or reaches it, wins outright; this breaks unbounded deuce.
- match_over / match_winner: registered, updated on the same edge as the score that decides the match. Once set, they hold; all arming and commits are blocked.
- clear_match: zeroes scores, rounds, pending, match_over, match_winner and bad_winner; sets done_q to 1. It has priority over a same-cycle commit, and that commit is lost.
- Async reset: every register is cleared, except done_q, which is set to 1.

## Timing
- Reset values: scores 0, match_over 0, match_winner 0, rounds 0, score_evt 0, bad_winner 0.
- Latency: done sampled high at edge t (low at t−1) -> pending set at edge t -> scores, rounds, score_evt and match outputs update at edge t+1.
- score_evt is high exactly in the cycle after edge t+1.
- Minimum round spacing: done low for 1 cycle, then high, gives a new round.
- Back-to-back: a done_rise at the commit edge re-arms pending on that edge.
- winner is sampled only at the commit edge; its value at arm time is irrelevant.
- reset_n deasserting mid-round: pending is lost and no increment occurs for the in-flight round.

## Test plan
- Defaults: 7 rounds with winner=01 -> scores[2:0] goes 1..7; match_over=1 and match_winner=01 one cycle after the 7th commit; an 8th done pulse leaves scores and rounds=7 unchanged.
- Hold done high 20 cycles with winner=10 -> exactly one increment to player 1; one score_evt pulse.
- WIN_BY=2, MATCH_POINTS=3, SCORE_W=3: alternate wins to 6–6, then player 0 scores to 7 -> immediate win by saturation (match_winner=01).
- WIN_BY=2: at 3–2, player 0 wins next round -> 4–2, match_over=1. At 3–3 then 4–3 -> not over.
- winner=11 at commit -> scores unchanged, bad_winner=1, rounds +1. winner=00 -> draw, rounds +1, bad_winner unchanged.
- Boundary controls:
  - clear_match asserted on the commit edge -> all outputs 0 and no increment.
  - reset_n pulsed low while done is high -> outputs 0; no increment until done toggles low then high.

Source files
------------

// File: rtl/multi_scoreboard.sv
// Match scoreboard for the tug-of-war family: counts one point per committed round,
// detects the match winner (target + win-by margin, or saturation) and freezes until cleared.
module multi_scoreboard #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 3,
    parameter int MATCH_POINTS = 7,
    parameter int WIN_BY       = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear_match,
    input  logic                           done,
    input  logic [NUM_PLAYERS-1:0]         winner,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           match_over,
    output logic [NUM_PLAYERS-1:0]         match_winner,
    output logic [7:0]                     rounds,
    output logic                           score_evt,
    output logic                           bad_winner
);
    localparam int EW = SCORE_W + 2;
    localparam logic [SCORE_W-1:0]     SMAX   = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]     ONE_S  = SCORE_W'(1);
    localparam logic [NUM_PLAYERS-1:0] ONE_P  = NUM_PLAYERS'(1);
    localparam logic [EW-1:0]          MP_EXT = EW'(MATCH_POINTS);
    localparam logic [EW-1:0]          WB_EXT = EW'(WIN_BY);

    logic                                  done_q;
    logic                                  pending_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_d;
    logic [7:0]                            rounds_q;
    logic                                  evt_q;
    logic                                  over_q;
    logic [NUM_PLAYERS-1:0]                mwin_q;
    logic                                  bad_q;

    logic                   done_rise;
    logic                   commit;
    logic                   w_zero;
    logic                   w_multi;
    logic [NUM_PLAYERS-1:0] inc_vec;
    logic [NUM_PLAYERS-1:0] win_vec;

    assign done_rise = done & ~done_q;
    // A commit only counts if done is still high on the edge after arming.
    assign commit    = pending_q & done & ~over_q;
    assign w_zero    = (winner == '0);
    assign w_multi   = ((winner & (winner - ONE_P)) != '0);
    assign inc_vec   = (commit && !w_zero && !w_multi) ? winner : '0;

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [SCORE_W-1:0] max_other;
        logic [EW-1:0]      own_ext;
        logic [EW-1:0]      other_ext;

        assign score_d[gi] = (inc_vec[gi] && score_q[gi] != SMAX) ? score_q[gi] + ONE_S
                                                                  : score_q[gi];

        always_comb begin
            max_other = '0;
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j != gi && score_d[j] > max_other) begin
                    max_other = score_d[j];
                end
            end
        end

        assign own_ext   = EW'(score_d[gi]);
        assign other_ext = EW'(max_other);
        // Only the player who just scored can newly satisfy the win condition.
        assign win_vec[gi] = inc_vec[gi] &&
                             ((score_q[gi] == SMAX) || (score_d[gi] == SMAX) ||
                              ((own_ext >= MP_EXT) && (own_ext >= other_ext + WB_EXT)));

        assign scores[gi*SCORE_W +: SCORE_W] = score_q[gi];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q    <= 1'b1;
            pending_q <= 1'b0;
            score_q   <= '0;
            rounds_q  <= '0;
            evt_q     <= 1'b0;
            over_q    <= 1'b0;
            mwin_q    <= '0;
            bad_q     <= 1'b0;
        end else if (clear_match) begin
            done_q    <= 1'b1;
            pending_q <= 1'b0;
            score_q   <= '0;
            rounds_q  <= '0;
            evt_q     <= 1'b0;
            over_q    <= 1'b0;
            mwin_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            done_q    <= done;
            pending_q <= done_rise & ~over_q;
            score_q   <= score_d;
            evt_q     <= commit;
            if (commit && rounds_q != 8'hFF) begin
                rounds_q <= rounds_q + 8'd1;
            end
            if (commit && w_multi) begin
                bad_q <= 1'b1;
            end
            if (win_vec != '0) begin
                over_q <= 1'b1;
                mwin_q <= win_vec;
            end
        end
    end

    assign match_over   = over_q;
    assign match_winner = mwin_q;
    assign rounds       = rounds_q;
    assign score_evt    = evt_q;
    assign bad_winner   = bad_q;
endmodule

// File: tb/tb_multi_scoreboard.sv
// Directed bench for multi_scoreboard: default instance (first to 7, win by 1) and a
// second instance (first to 3, win by 2) sharing the same stimulus.
module tb_multi_scoreboard;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_match;
    logic       done;
    logic [1:0] winner;

    logic [5:0] scores_a, scores_b;
    logic       over_a, over_b;
    logic [1:0] mw_a, mw_b;
    logic [7:0] rounds_a, rounds_b;
    logic       evt_a, evt_b;
    logic       bad_a, bad_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .clear_match(clear_match), .done(done),
        .winner(winner), .scores(scores_a), .match_over(over_a), .match_winner(mw_a),
        .rounds(rounds_a), .score_evt(evt_a), .bad_winner(bad_a)
    );

    multi_scoreboard #(.NUM_PLAYERS(2), .SCORE_W(3), .MATCH_POINTS(3), .WIN_BY(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear_match(clear_match), .done(done),
        .winner(winner), .scores(scores_b), .match_over(over_b), .match_winner(mw_b),
        .rounds(rounds_b), .score_evt(evt_b), .bad_winner(bad_b)
    );

    typedef struct {
        logic       clr;
        logic [1:0] w;
        int         s0;
        int         s1;
        int         rnd;
        logic       over;
        logic [1:0] mw;
        logic       bad;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One full round: done rises, held for the commit edge, then dropped.
    task automatic play(input logic [1:0] w);
        winner = w;
        done   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear_match = 1'b1;
        @(negedge clk);
        clear_match = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int evt_cnt;
        int evt_at;

        for (int i = 0; i < 7; i++) begin
            vec[i] = '{1'b0, 2'b01, i + 1, 0, i + 1, (i == 6), (i == 6) ? 2'b01 : 2'b00, 1'b0};
        end
        vec[7]  = '{1'b0, 2'b01, 7, 0, 7, 1'b1, 2'b01, 1'b0};
        vec[8]  = '{1'b1, 2'b10, 0, 1, 1, 1'b0, 2'b00, 1'b0};
        vec[9]  = '{1'b0, 2'b11, 0, 1, 2, 1'b0, 2'b00, 1'b1};
        vec[10] = '{1'b0, 2'b00, 0, 1, 3, 1'b0, 2'b00, 1'b1};
        vec[11] = '{1'b0, 2'b10, 0, 2, 4, 1'b0, 2'b00, 1'b1};
        vec[12] = '{1'b0, 2'b01, 1, 2, 5, 1'b0, 2'b00, 1'b1};

        reset_n     = 1'b0;
        clear_match = 1'b0;
        done        = 1'b0;
        winner      = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("reset scores", int'(scores_a), 0);
        chk("reset over", int'(over_a), 0);
        chk("reset mw", int'(mw_a), 0);
        chk("reset rounds", int'(rounds_a), 0);
        chk("reset evt", int'(evt_a), 0);
        chk("reset bad", int'(bad_a), 0);

        for (int i = 0; i < 13; i++) begin
            if (vec[i].clr) do_clear();
            play(vec[i].w);
            $display("vec %0d w=%b s0=%0d s1=%0d rounds=%0d over=%b mw=%b bad=%b",
                     i, vec[i].w, scores_a[2:0], scores_a[5:3], rounds_a, over_a, mw_a, bad_a);
            chk($sformatf("vec%0d s0", i), int'(scores_a[2:0]), vec[i].s0);
            chk($sformatf("vec%0d s1", i), int'(scores_a[5:3]), vec[i].s1);
            chk($sformatf("vec%0d rounds", i), int'(rounds_a), vec[i].rnd);
            chk($sformatf("vec%0d over", i), int'(over_a), int'(vec[i].over));
            chk($sformatf("vec%0d mw", i), int'(mw_a), int'(vec[i].mw));
            chk($sformatf("vec%0d bad", i), int'(bad_a), int'(vec[i].bad));
        end

        // done held high for 20 cycles: exactly one commit
        do_clear();
        winner  = 2'b10;
        done    = 1'b1;
        evt_cnt = 0;
        evt_at  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (evt_a) begin
                evt_cnt++;
                if (evt_at < 0) evt_at = i;
            end
        end
        done = 1'b0;
        @(negedge clk);
        $display("hold20 s1=%0d rounds=%0d pulses=%0d first=%0d",
                 scores_a[5:3], rounds_a, evt_cnt, evt_at);
        chk("hold20 pulses", evt_cnt, 1);
        chk("hold20 evt cycle", evt_at, 1);
        chk("hold20 s1", int'(scores_a[5:3]), 1);
        chk("hold20 s0", int'(scores_a[2:0]), 0);
        chk("hold20 rounds", int'(rounds_a), 1);

        // clear_match on the commit edge wins over the commit
        play(2'b01);
        winner = 2'b01;
        done   = 1'b1;
        @(negedge clk);
        clear_match = 1'b1;
        @(negedge clk);
        clear_match = 1'b0;
        $display("clear@commit scores=%h rounds=%0d evt=%b", scores_a, rounds_a, evt_a);
        chk("clr commit scores", int'(scores_a), 0);
        chk("clr commit rounds", int'(rounds_a), 0);
        chk("clr commit evt", int'(evt_a), 0);
        chk("clr commit over", int'(over_a), 0);
        done = 1'b0;
        @(negedge clk);

        // async reset mid-round with done high
        play(2'b10);
        chk("pre-reset s1", int'(scores_a[5:3]), 1);
        winner = 2'b10;
        done   = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async reset scores", int'(scores_a), 0);
        chk("async reset rounds", int'(rounds_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("post-reset held done scores=%h rounds=%0d", scores_a, rounds_a);
        chk("held done scores", int'(scores_a), 0);
        chk("held done rounds", int'(rounds_a), 0);
        done = 1'b0;
        @(negedge clk);
        play(2'b10);
        chk("retoggle s1", int'(scores_a[5:3]), 1);
        chk("retoggle rounds", int'(rounds_a), 1);

        // win-by-2 instance: deuce up to 6-6, then saturation decides
        do_clear();
        for (int i = 0; i < 12; i++) begin
            play((i % 2 == 0) ? 2'b01 : 2'b10);
            $display("deuce %0d s0=%0d s1=%0d over=%b", i, scores_b[2:0], scores_b[5:3], over_b);
            chk($sformatf("deuce%0d over", i), int'(over_b), 0);
        end
        chk("deuce s0", int'(scores_b[2:0]), 6);
        chk("deuce s1", int'(scores_b[5:3]), 6);
        play(2'b01);
        $display("saturate s0=%0d s1=%0d over=%b mw=%b", scores_b[2:0], scores_b[5:3], over_b, mw_b);
        chk("sat s0", int'(scores_b[2:0]), 7);
        chk("sat over", int'(over_b), 1);
        chk("sat mw", int'(mw_b), 1);

        // win-by-2: 3-2 is not decided, 4-2 is
        do_clear();
        play(2'b01); play(2'b10); play(2'b01); play(2'b10); play(2'b01);
        chk("3-2 over", int'(over_b), 0);
        play(2'b01);
        $display("winby2 s0=%0d s1=%0d over=%b mw=%b", scores_b[2:0], scores_b[5:3], over_b, mw_b);
        chk("4-2 s0", int'(scores_b[2:0]), 4);
        chk("4-2 s1", int'(scores_b[5:3]), 2);
        chk("4-2 over", int'(over_b), 1);
        chk("4-2 mw", int'(mw_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
